// File: rtl/riscv_div_pkg.sv
// Shared opcode values and FSM state encoding for the RV32M divide sequencer.
package riscv_div_pkg;

   localparam logic [1:0] DIV  = 2'b00;
   localparam logic [1:0] DIVU = 2'b01;
   localparam logic [1:0] REM  = 2'b10;
   localparam logic [1:0] REMU = 2'b11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } div_state_e;

endpackage

// File: rtl/adder_n_subtractor.sv
// Ripple-style add/subtract primitive: sum_o = a_i + (sub_i ? ~b_i : b_i) + c_i.
module adder_n_subtractor #(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] sum_o
);

   assign sum_o = a_i + (sub_i ? ~b_i : b_i) + {{(WIDTH-1){1'b0}}, c_i};

endmodule

// File: rtl/div_sequencer.sv
// Restoring shift-subtract divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to skip the iteration loop for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start; |dividend| formed on accept
// PREP  | |divisor| formed, signs latched, counter loaded
// CALC  | one restoring step per cycle, WIDTH cycles
// FIX   | sign correction and special-case override into result
// DONE  | done pulse, then back to IDLE
module div_sequencer
   import riscv_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             kill,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam int AW = WIDTH + 1;

   div_state_e       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_raw_q, a_raw_d, b_raw_q, b_raw_d, b_abs_q, b_abs_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, result_q, result_d;
   logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [AW-1:0]    add_a, add_b, add_sum;
   logic [WIDTH-1:0] fix_val;
   logic             signed_in, signed_q, div_zero, ovf, special;

   adder_n_subtractor #(.WIDTH(AW)) u_addsub (
      .a_i   (add_a),
      .b_i   (add_b),
      .sub_i (1'b1),
      .c_i   (1'b1),
      .sum_o (add_sum)
   );

   assign signed_in = (op == DIV) || (op == REM);
   assign signed_q  = (op_q == DIV) || (op_q == REM);
   assign div_zero  = (b_raw_q == '0);
   assign ovf       = signed_q && (a_raw_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_raw_q == '1);
   assign special   = div_zero || ovf;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_raw_d   = a_raw_q;
      b_raw_d   = b_raw_q;
      b_abs_d   = b_abs_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      result_d  = result_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      cnt_d     = cnt_q;
      add_a     = '0;
      add_b     = '0;
      fix_val   = '0;

      // The single adder negates with a=0 outside CALC, and subtracts the divisor inside it.
      unique case (state_q)
         IDLE: begin
            add_b = {1'b0, dividend};
            if (start && !kill) begin
               state_d = PREP;
               op_d    = op;
               a_raw_d = dividend;
               b_raw_d = divisor;
               quo_d   = (signed_in && dividend[WIDTH-1]) ? add_sum[WIDTH-1:0] : dividend;
            end
         end
         PREP: begin
            add_b     = {1'b0, b_raw_q};
            b_abs_d   = (signed_q && b_raw_q[WIDTH-1]) ? add_sum[WIDTH-1:0] : b_raw_q;
            neg_quo_d = signed_q && (a_raw_q[WIDTH-1] ^ b_raw_q[WIDTH-1]);
            neg_rem_d = signed_q && a_raw_q[WIDTH-1];
            rem_d     = '0;
            cnt_d     = CW'(WIDTH - 1);
            state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
            if (special) state_d = FIX;
`endif
         end
         CALC: begin
            add_a = {rem_q, quo_q[WIDTH-1]};
            add_b = {1'b0, b_abs_q};
            rem_d = add_sum[AW-1] ? add_a[WIDTH-1:0] : add_sum[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~add_sum[AW-1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            add_b   = {1'b0, op_q[1] ? rem_q : quo_q};
            fix_val = (op_q[1] ? neg_rem_q : neg_quo_q) ? add_sum[WIDTH-1:0] : add_b[WIDTH-1:0];
            if (div_zero)
               fix_val = op_q[1] ? a_raw_q : '1;
            else if (ovf)
               fix_val = op_q[1] ? '0 : a_raw_q;
            result_d = fix_val;
            state_d  = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (kill && state_q != IDLE) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= '0;
         a_raw_q   <= '0;
         b_raw_q   <= '0;
         b_abs_q   <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         result_q  <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_raw_q   <= a_raw_d;
         b_raw_q   <= b_raw_d;
         b_abs_q   <= b_abs_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         result_q  <= result_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         cnt_q     <= cnt_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule
